// File: rtl/tile_move_engine.sv
`timescale 1ns/1ps
// 2048 move sequencer: owns the 4x4 exponent grid, slides/merges one line per cycle,
// spawns a tile from a free-running LFSR and re-evaluates the won/game-over flags.
module tile_move_engine #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned WIN_EXP = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    output logic        move_done,
    output logic        moved,
    input  logic        new_game,
    input  logic        ld_valid,
    input  logic [1:0]  ld_x,
    input  logic [1:0]  ld_y,
    input  logic [3:0]  ld_value,
    input  logic [1:0]  rd_x,
    input  logic [1:0]  rd_y,
    output logic [3:0]  rd_value,
    output logic [15:0] score,
    output logic        won,
    output logic        game_over
);
    typedef enum logic [1:0] {StIdle, StSlide, StSpawn, StCheck} state_e;
    localparam logic [4:0] WinExp = 5'(WIN_EXP);

    state_e      state_q, state_d;
    logic [3:0]  grid_q [16];
    logic [3:0]  grid_d [16];
    logic [15:0] lfsr_q, lfsr_d, score_q, score_d;
    logic [1:0]  dir_q, dir_d, line_q, line_d;
    logic [3:0]  start_q, start_d, val_q, val_d, k_q, k_d;
    logic        changed_q, changed_d, won_q, won_d, game_over_q, game_over_d;
    logic        move_done_q, move_done_d, moved_q, moved_d;

    logic [3:0]  line_idx [4];
    logic [3:0]  line_in  [4];
    logic [3:0]  line_out [4];
    logic [3:0]  cmp      [5];
    logic [2:0]  n;
    logic [1:0]  o;
    logic        skip, line_chg, any_win, board_full, has_pair;
    logic [16:0] gain;
    logic [17:0] score_sum;
    logic [15:0] score_sat;
    logic [3:0]  spawn_idx;

    // Element 0 of each line sits against the destination wall.
    always_comb begin
        for (int e = 0; e < 4; e++) begin
            unique case (dir_q)
                2'd0:    line_idx[e] = {2'(e), line_q};
                2'd1:    line_idx[e] = {~2'(e), line_q};
                2'd2:    line_idx[e] = {line_q, 2'(e)};
                default: line_idx[e] = {line_q, ~2'(e)};
            endcase
            line_in[e] = grid_q[line_idx[e]];
        end
        for (int e = 0; e < 5; e++) cmp[e] = '0;
        n = '0;
        for (int e = 0; e < 4; e++) begin
            if (line_in[e] != 4'd0) begin
                cmp[n] = line_in[e];
                n      = n + 3'd1;
            end
        end
        for (int e = 0; e < 4; e++) line_out[e] = '0;
        o    = '0;
        skip = 1'b0;
        gain = '0;
        for (int e = 0; e < 4; e++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (cmp[e] != 4'd0) begin
                if (cmp[e] == cmp[e+1] && cmp[e] != 4'd15) begin
                    line_out[o] = cmp[e] + 4'd1;
                    gain        = gain + (17'd1 << (cmp[e] + 4'd1));
                    skip        = 1'b1;
                end else begin
                    line_out[o] = cmp[e];
                end
                o = o + 2'd1;
            end
        end
        line_chg = 1'b0;
        for (int e = 0; e < 4; e++) line_chg = line_chg | (line_out[e] != line_in[e]);
        score_sum = {2'b00, score_q} + {1'b0, gain};
        score_sat = (score_sum[17:16] != 2'b00) ? 16'hFFFF : score_sum[15:0];
    end

    always_comb begin
        any_win    = 1'b0;
        board_full = 1'b1;
        has_pair   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            any_win    = any_win | ({1'b0, grid_q[i]} >= WinExp);
            board_full = board_full & (grid_q[i] != 4'd0);
        end
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 3; x++) begin
                has_pair = has_pair | (grid_q[4*y+x] == grid_q[4*y+x+1]);
            end
        end
        for (int i = 0; i < 12; i++) has_pair = has_pair | (grid_q[i] == grid_q[i+4]);
    end

    assign spawn_idx = start_q + k_q;

    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        dir_d       = dir_q;
        line_d      = line_q;
        changed_d   = changed_q;
        start_d     = start_q;
        val_d       = val_q;
        k_d         = k_q;
        score_d     = score_q;
        won_d       = won_q;
        game_over_d = game_over_q;
        move_done_d = 1'b0;
        moved_d     = moved_q;
        unique case (state_q)
            StIdle: begin
                if (ld_valid) begin
                    grid_d[{ld_y, ld_x}] = ld_value;
                end else if (move_valid && move_ready) begin
                    dir_d     = move_dir;
                    line_d    = '0;
                    changed_d = 1'b0;
                    state_d   = StSlide;
                end
            end
            StSlide: begin
                for (int e = 0; e < 4; e++) grid_d[line_idx[e]] = line_out[e];
                score_d   = score_sat;
                changed_d = changed_q | line_chg;
                line_d    = line_q + 2'd1;
                if (line_q == 2'd3) begin
                    if (changed_q | line_chg) begin
                        state_d = StSpawn;
                        start_d = lfsr_q[3:0];
                        val_d   = (lfsr_q[6:4] == 3'd0) ? 4'd2 : 4'd1;
                        k_d     = '0;
                    end else begin
                        state_d = StCheck;
                    end
                end
            end
            StSpawn: begin
                if (grid_q[spawn_idx] == 4'd0) begin
                    grid_d[spawn_idx] = val_q;
                    state_d           = StCheck;
                end else if (k_q == 4'd15) begin
                    state_d = StCheck;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            StCheck: begin
                won_d       = won_q | any_win;
                game_over_d = board_full & ~has_pair;
                move_done_d = 1'b1;
                moved_d     = changed_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Restart aborts whatever is in flight; the LFSR keeps running.
        if (new_game) begin
            for (int i = 0; i < 16; i++) grid_d[i] = '0;
            grid_d[5]   = 4'd1;
            grid_d[10]  = 4'd1;
            score_d     = '0;
            won_d       = 1'b0;
            game_over_d = 1'b0;
            move_done_d = 1'b0;
            moved_d     = 1'b0;
            state_d     = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            for (int i = 0; i < 16; i++) grid_q[i] <= '0;
            grid_q[5]   <= 4'd1;
            grid_q[10]  <= 4'd1;
            lfsr_q      <= SEED;
            dir_q       <= '0;
            line_q      <= '0;
            changed_q   <= 1'b0;
            start_q     <= '0;
            val_q       <= '0;
            k_q         <= '0;
            score_q     <= '0;
            won_q       <= 1'b0;
            game_over_q <= 1'b0;
            move_done_q <= 1'b0;
            moved_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            lfsr_q      <= lfsr_d;
            dir_q       <= dir_d;
            line_q      <= line_d;
            changed_q   <= changed_d;
            start_q     <= start_d;
            val_q       <= val_d;
            k_q         <= k_d;
            score_q     <= score_d;
            won_q       <= won_d;
            game_over_q <= game_over_d;
            move_done_q <= move_done_d;
            moved_q     <= moved_d;
        end
    end

    assign move_ready = (state_q == StIdle) && !game_over_q;
    assign move_done  = move_done_q;
    assign moved      = moved_q;
    assign rd_value   = grid_q[{rd_y, rd_x}];
    assign score      = score_q;
    assign won        = won_q;
    assign game_over  = game_over_q;
endmodule
